// File: rtl/class_pkg.sv
`default_nettype none
// ============================================================================
// Module      : class_pkg
// Description : Shared types for the classifier hash-bucket engines: the
//               32-bit way entry, the 4-way bucket, the request op, the
//               response status and the insert/delete FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package class_pkg;

    localparam int WAYS    = 4;
    localparam int ENTRY_W = 32;
    localparam int HASH_W  = 13;
    localparam int PTR_W   = 15;
    // The entry is always 32 bits; whatever hash and pointer do not use is pad.
    localparam int PAD_W   = ENTRY_W - 1 - PTR_W - HASH_W;

    typedef struct packed {
        logic              vld;
        logic [PTR_W-1:0]  ptr;
        logic [PAD_W-1:0]  pad;
        logic [HASH_W-1:0] hash;
    } entry_t;

    // Packed so way i lands on bits [i*32 +: 32] of the flat bucket.
    typedef entry_t [WAYS-1:0] bucket_t;

    typedef enum logic [1:0] {
        STS_OK        = 2'd0,
        STS_FULL      = 2'd1,
        STS_NOT_FOUND = 2'd2,
        STS_DUP       = 2'd3
    } status_e;

    typedef enum logic {
        OP_INS = 1'b0,
        OP_DEL = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_EVAL = 3'd3,
        S_WR   = 3'd4,
        S_RSP  = 3'd5
    } state_e;

    // Builds a valid entry; pad is always zero.
    function automatic entry_t make_entry(input logic [PTR_W-1:0]  ptr,
                                          input logic [HASH_W-1:0] hash);
        entry_t e;
        e.vld  = 1'b1;
        e.ptr  = ptr;
        e.pad  = '0;
        e.hash = hash;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/class_hbkt_slot_sel.sv
`default_nettype none
// ============================================================================
// Module      : class_hbkt_slot_sel
// Description : Combinational scan of one 4-way bucket. Reports the lowest
//               free way, the lowest valid way whose hash and pointer both
//               match the key, and the number of valid ways.
// Ports       : bkt         - flat 128-bit bucket
//               key_hash    - hash as stored in this table
//               key_ptr     - value pointer to match
//               free_found  / free_idx  - lowest free way
//               match_found / match_idx - lowest matching valid way
//               vld_cnt     - number of valid ways (0..4)
// Revision    : 1.0 - initial release
// ============================================================================
module class_hbkt_slot_sel
    import class_pkg::*;
(
    input  logic [127:0]      bkt,
    input  logic [HASH_W-1:0] key_hash,
    input  logic [PTR_W-1:0]  key_ptr,
    output logic              free_found,
    output logic [1:0]        free_idx,
    output logic              match_found,
    output logic [1:0]        match_idx,
    output logic [2:0]        vld_cnt
);

    bucket_t b;
    assign b = bkt;

    // Scanning from the top way down lets the lowest hit overwrite the others.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = 2'd0;
        match_found = 1'b0;
        match_idx   = 2'd0;
        vld_cnt     = 3'd0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!b[i].vld) begin
                free_found = 1'b1;
                free_idx   = 2'(i);
            end else begin
                vld_cnt = vld_cnt + 3'd1;
                if ((b[i].hash == key_hash) && (b[i].ptr == key_ptr)) begin
                    match_found = 1'b1;
                    match_idx   = 2'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/class_hbkt_ins.sv
`default_nettype none
// ============================================================================
// Module      : class_hbkt_ins
// Description : Hash-bucket maintenance engine for the two-table 4-way
//               classifier hash. Takes one insert/delete at a time, reads
//               both candidate buckets, picks a way, writes the modified
//               bucket back and returns a status. Keeps a saturating count
//               of valid entries across both tables.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               req_*                      - request handshake and payload
//               ht_rd_*                    - bucket read strobe / indexes
//               ht_rd_vld, ht_t1/t2_data   - returned buckets
//               ht_wr_t1/t2, ht_wr_addr/data - one-cycle bucket write
//               rsp_vld, rsp_status        - one-cycle response
//               occ_cnt                    - valid entries in both tables
// Config      : CLASS_HBKT_INS_BAL_EN - insert goes to the table whose
//               bucket has fewer valid ways (T1 on a tie) instead of the
//               strict T1-first policy.
// Revision    : 1.0 - initial release
// ============================================================================
module class_hbkt_ins
    import class_pkg::*;
#(
    parameter int HASH_WIDTH = 13,
    parameter int PTR_WIDTH  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_op,
    input  logic [HASH_WIDTH-1:0] req_h1k,
    input  logic [HASH_WIDTH-1:0] req_h2k,
    input  logic [PTR_WIDTH-1:0]  req_ptr,
    output logic                  ht_rd_req,
    output logic [HASH_WIDTH-1:0] ht_rd_addr_t1,
    output logic [HASH_WIDTH-1:0] ht_rd_addr_t2,
    input  logic                  ht_rd_vld,
    input  logic [127:0]          ht_t1_data,
    input  logic [127:0]          ht_t2_data,
    output logic                  ht_wr_t1,
    output logic                  ht_wr_t2,
    output logic [HASH_WIDTH-1:0] ht_wr_addr,
    output logic [127:0]          ht_wr_data,
    output logic                  rsp_vld,
    output logic [1:0]            rsp_status,
    output logic [HASH_WIDTH+3:0] occ_cnt
);

    localparam logic [HASH_WIDTH+3:0] OCC_MAX = '1;

    state_e                  state_q, state_d;
    op_e                     op_q, op_d;
    logic [HASH_WIDTH-1:0]   h1k_q, h1k_d;
    logic [HASH_WIDTH-1:0]   h2k_q, h2k_d;
    logic [PTR_WIDTH-1:0]    ptr_q, ptr_d;
    bucket_t                 bkt_t1_q, bkt_t1_d;
    bucket_t                 bkt_t2_q, bkt_t2_d;
    logic                    wr_tbl_t2_q, wr_tbl_t2_d;
    bucket_t                 wr_data_q, wr_data_d;
    status_e                 status_q, status_d;
    logic [HASH_WIDTH+3:0]   occ_cnt_q, occ_cnt_d;

    // ------------------------------------------------------------------------
    // Per-table bucket scans. T1 ways hold h2k, T2 ways hold h1k.
    // ------------------------------------------------------------------------
    logic       t1_free_found, t1_match_found;
    logic [1:0] t1_free_idx, t1_match_idx;
    logic [2:0] t1_vld_cnt;
    logic       t2_free_found, t2_match_found;
    logic [1:0] t2_free_idx, t2_match_idx;
    logic [2:0] t2_vld_cnt;

    class_hbkt_slot_sel u_sel_t1 (
        .bkt         (bkt_t1_q),
        .key_hash    (h2k_q),
        .key_ptr     (ptr_q),
        .free_found  (t1_free_found),
        .free_idx    (t1_free_idx),
        .match_found (t1_match_found),
        .match_idx   (t1_match_idx),
        .vld_cnt     (t1_vld_cnt)
    );

    class_hbkt_slot_sel u_sel_t2 (
        .bkt         (bkt_t2_q),
        .key_hash    (h1k_q),
        .key_ptr     (ptr_q),
        .free_found  (t2_free_found),
        .free_idx    (t2_free_idx),
        .match_found (t2_match_found),
        .match_idx   (t2_match_idx),
        .vld_cnt     (t2_vld_cnt)
    );

    // ------------------------------------------------------------------------
    // Way selection: decides whether to write, which table, which way, and
    // the status to report.
    // ------------------------------------------------------------------------
    logic    eval_wr;
    logic    eval_tbl_t2;
    logic [1:0] eval_way;
    status_e eval_status;

    always_comb begin
        eval_wr     = 1'b0;
        eval_tbl_t2 = 1'b0;
        eval_way    = 2'd0;
        eval_status = STS_OK;
        if (op_q == OP_INS) begin
            if (t1_match_found || t2_match_found) begin
                eval_status = STS_DUP;
`ifdef CLASS_HBKT_INS_BAL_EN
            end else if (t1_free_found && t2_free_found) begin
                // Both have room: prefer the emptier bucket, T1 on a tie.
                eval_wr     = 1'b1;
                eval_tbl_t2 = (t2_vld_cnt < t1_vld_cnt);
                eval_way    = (t2_vld_cnt < t1_vld_cnt) ? t2_free_idx : t1_free_idx;
`endif
            end else if (t1_free_found) begin
                eval_wr     = 1'b1;
                eval_tbl_t2 = 1'b0;
                eval_way    = t1_free_idx;
            end else if (t2_free_found) begin
                eval_wr     = 1'b1;
                eval_tbl_t2 = 1'b1;
                eval_way    = t2_free_idx;
            end else begin
                eval_status = STS_FULL;
            end
        end else begin
            if (t1_match_found) begin
                eval_wr     = 1'b1;
                eval_tbl_t2 = 1'b0;
                eval_way    = t1_match_idx;
            end else if (t2_match_found) begin
                eval_wr     = 1'b1;
                eval_tbl_t2 = 1'b1;
                eval_way    = t2_match_idx;
            end else begin
                eval_status = STS_NOT_FOUND;
            end
        end
    end

`ifndef CLASS_HBKT_INS_BAL_EN
    // Way counts only steer the balanced policy.
    logic unused_vld_cnt;
    assign unused_vld_cnt = ^{t1_vld_cnt, t2_vld_cnt};
`endif

    // ------------------------------------------------------------------------
    // New bucket: the selected way is replaced (new entry on insert, zero on
    // delete), the other three pass through untouched.
    // ------------------------------------------------------------------------
    bucket_t new_bkt;
    entry_t  new_ent;

    always_comb begin
        new_ent = '0;
        if (op_q == OP_INS) begin
            new_ent = make_entry(ptr_q, eval_tbl_t2 ? h1k_q : h2k_q);
        end
        new_bkt           = eval_tbl_t2 ? bkt_t2_q : bkt_t1_q;
        new_bkt[eval_way] = new_ent;
    end

    // ------------------------------------------------------------------------
    // FSM: next state, register updates and strobes.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        h1k_d       = h1k_q;
        h2k_d       = h2k_q;
        ptr_d       = ptr_q;
        bkt_t1_d    = bkt_t1_q;
        bkt_t2_d    = bkt_t2_q;
        wr_tbl_t2_d = wr_tbl_t2_q;
        wr_data_d   = wr_data_q;
        status_d    = status_q;
        occ_cnt_d   = occ_cnt_q;
        req_rdy     = 1'b0;
        ht_rd_req   = 1'b0;
        ht_wr_t1    = 1'b0;
        ht_wr_t2    = 1'b0;
        rsp_vld     = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_rdy = 1'b1;
                if (req_vld) begin
                    op_d    = op_e'(req_op);
                    h1k_d   = req_h1k;
                    h2k_d   = req_h2k;
                    ptr_d   = req_ptr;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                ht_rd_req = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (ht_rd_vld) begin
                    bkt_t1_d = ht_t1_data;
                    bkt_t2_d = ht_t2_data;
                    state_d  = S_EVAL;
                end
            end
            S_EVAL: begin
                status_d    = eval_status;
                wr_tbl_t2_d = eval_tbl_t2;
                wr_data_d   = new_bkt;
                state_d     = eval_wr ? S_WR : S_RSP;
            end
            S_WR: begin
                // Only an OK insert/delete ever reaches this state.
                ht_wr_t1 = !wr_tbl_t2_q;
                ht_wr_t2 = wr_tbl_t2_q;
                if (op_q == OP_INS) begin
                    if (occ_cnt_q != OCC_MAX) begin
                        occ_cnt_d = occ_cnt_q + 1'b1;
                    end
                end else begin
                    if (occ_cnt_q != '0) begin
                        occ_cnt_d = occ_cnt_q - 1'b1;
                    end
                end
                state_d = S_RSP;
            end
            S_RSP: begin
                rsp_vld = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_INS;
            h1k_q       <= '0;
            h2k_q       <= '0;
            ptr_q       <= '0;
            bkt_t1_q    <= '0;
            bkt_t2_q    <= '0;
            wr_tbl_t2_q <= 1'b0;
            wr_data_q   <= '0;
            status_q    <= STS_OK;
            occ_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            h1k_q       <= h1k_d;
            h2k_q       <= h2k_d;
            ptr_q       <= ptr_d;
            bkt_t1_q    <= bkt_t1_d;
            bkt_t2_q    <= bkt_t2_d;
            wr_tbl_t2_q <= wr_tbl_t2_d;
            wr_data_q   <= wr_data_d;
            status_q    <= status_d;
            occ_cnt_q   <= occ_cnt_d;
        end
    end

    assign ht_rd_addr_t1 = h1k_q;
    assign ht_rd_addr_t2 = h2k_q;
    assign ht_wr_addr    = wr_tbl_t2_q ? h2k_q : h1k_q;
    assign ht_wr_data    = wr_data_q;
    assign rsp_status    = status_q;
    assign occ_cnt       = occ_cnt_q;

endmodule
`default_nettype wire
